fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of IMMGEN. Holds the PC and runs a request/ready handshake with instruction memory. Registers each returned word together with its PC, and presents it with a decoded immediate-format select, so the word drives IMMGEN's `inst_imm` and the select drives `immsel_g`. Supports decode-stage stall and execute-stage redirect (branch/jump).

## Interface
- `RESET_PC`, default 32'h0100_0000: PC after reset.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: word-aligned fetch address; bits[1:0] always 0.
- `imem_ready` in 1: memory accepts the request and returns `imem_rdata` in the same cycle.
- `imem_rdata` in 32: instruction word, valid when `imem_req & imem_ready`.
- `stall` in 1: decode cannot consume; hold the current instruction.
- `redirect_valid` in 1: taken branch/jump this cycle.
- `redirect_pc` in 32: redirect target; bits[1:0] ignored (forced 0).
- `inst_valid` out 1: `inst_out`/`inst_pc`/`immsel` hold a live instruction.
- `inst_out` out 32: fetched instruction; goes to IMMGEN `inst_imm` and the decoder.
- `inst_pc` out 32: address of `inst_out`.
- `immsel` out 3: immediate format of `inst_out`; goes to IMMGEN `immsel_g`.

## Operation
- **Reset values**: `pc`=RESET_PC, state=FETCH, `inst_valid`=0, `inst_out`=32'h0000_0013 (NOP), `inst_pc`=RESET_PC, `immsel`=3'b010.
- While `rst`=1, `imem_req`=0. Any outstanding request is abandoned; memory shares the same reset.
- `imem_req` = (state FETCH or FLUSH) & ~rst.
- `imem_addr` = `pc` in FETCH; the latched in-flight address in FLUSH.
- **FETCH**:
  - On `imem_ready`: capture `inst_out`←rdata, `inst_pc`←pc, `pc`←pc+4, then go to VALID.
  - `redirect_valid` with `imem_ready`: discard the data, `pc`←redirect_pc, stay in FETCH.
  - `redirect_valid` without `imem_ready`: `pc`←redirect_pc, go to FLUSH; the address stays stable.
- **VALID**: `inst_valid`=1.
  - `redirect_valid`: `pc`←redirect_pc, go to FETCH (instruction killed).
  - Else if `stall`: stay; all outputs hold.
  - Else: go to FETCH (instruction consumed this cycle).
- **FLUSH**: request stays up at the old address.
  - On `imem_ready`: discard the data and go to FETCH.
  - A further `redirect_valid` updates `pc`; the last redirect wins.
- Redirect has priority over stall. Stall is ignored outside VALID.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 → 0.
- **`immsel` decode** (registered with `inst_out`), keyed on opcode[6:0]:
  - 0110111/0010111 → 000 (U)
  - 1101111 → 001 (J)
  - 0010011/0000011/1100111/1110011/0001111 → 010 (I)
  - 1100011 → 011 (B)
  - 0100011 → 100 (S)
  - 0110011 and all others → 111 (no immediate; IMMGEN outputs 0)

## Timing
- Handshake: `imem_addr` stays stable while `imem_req & ~imem_ready`. Transfer occurs on the edge where both are high.
- Latency: handshake in cycle N gives `inst_valid`=1 in N+1.
- Throughput: at most one instruction every 2 cycles (FETCH, VALID).
- Redirect in cycle N: `inst_valid`=0 in N+1, and `imem_addr`=redirect_pc in N+1 unless in FLUSH.
- `inst_valid`, `inst_out`, `inst_pc`, `immsel` are all registered. There is no combinational path from memory to these outputs.

## Structure
- Shared package `rv32i_pkg`:
  - opcode constants
  - immsel encodings IMM_U=000, IMM_J=001, IMM_I=010, IMM_B=011, IMM_S=100, IMM_NONE=111 (must match IMMGEN's case encoding)
  - NOP_INST=32'h0000_0013
  - fetch state enum {FETCH, VALID, FLUSH}
- One combinational sub-module `imm_sel_decode` (opcode[6:0] → immsel[2:0]), reused later by the main decoder.

## Test plan
- **Reset then straight-line fetch**: release `rst`; memory always ready returns 32'h00500093 at 0x0100_0000 → `imem_addr`=0x0100_0000, `inst_valid`=1 next cycle, `inst_pc`=0x0100_0000, `immsel`=010; next request at 0x0100_0004.
- **Wait states**: `imem_ready` low for 3 cycles → `imem_addr` constant; `inst_valid` rises exactly 1 cycle after the ready cycle.
- **Stall**: `stall`=1 for 4 cycles in VALID holding 32'hFE208EE3 → outputs frozen, `immsel`=011, no `imem_req`; fetch resumes the cycle after `stall` falls.
- **Redirect in VALID with stall**: `redirect_valid`=1, `redirect_pc`=0x0100_0102, `stall`=1 → `inst_valid`=0 next cycle, `imem_addr`=0x0100_0100.
- **Redirect during wait**: redirect to 0x0100_0040 while `imem_ready`=0 → old address held until ready, response discarded (`inst_valid` stays 0), then a request issues at 0x0100_0040.
- **Wrap and decode sweep**: `RESET_PC`=32'hFFFF_FFFC → second fetch at 0x0000_0000; returned words covering LUI, JAL, LW, SW, BEQ, ADD give `immsel` 000, 001, 010, 100, 011, 111.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the fetch stage and decode helpers:
// opcodes, immediate-format encodings, fetch FSM states.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_OPIMM   = 7'b0010011;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OP_MISCMEM = 7'b0001111;

  // Encodings must stay in lock-step with IMMGEN's immsel_g case items.
  typedef enum logic [2:0] {
    IMM_U    = 3'b000,
    IMM_J    = 3'b001,
    IMM_I    = 3'b010,
    IMM_B    = 3'b011,
    IMM_S    = 3'b100,
    IMM_NONE = 3'b111
  } immsel_e;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    VALID = 2'b01,
    FLUSH = 2'b10
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready bus; rdata returns in the accepting cycle.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/imm_sel_decode.sv
// Maps an RV32I opcode to the immediate format consumed by IMMGEN.
module imm_sel_decode
  import rv32i_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic [2:0] o_immsel
);

  // Opcode to immediate-format lookup; unknown opcodes carry no immediate.
  always_comb begin
    o_immsel = IMM_NONE;
    case (i_opcode)
      OP_LUI, OP_AUIPC:                                   o_immsel = IMM_U;
      OP_JAL:                                             o_immsel = IMM_J;
      OP_OPIMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_MISCMEM:  o_immsel = IMM_I;
      OP_BRANCH:                                          o_immsel = IMM_B;
      OP_STORE:                                           o_immsel = IMM_S;
      default:                                            o_immsel = IMM_NONE;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with instruction memory and
// presents one registered instruction (word, PC, immediate format) to decode.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
  input  logic               clk,
  input  logic               rst,
  fetch_unit_if.master       imem,
  input  logic               i_stall,
  input  logic               i_redirect_valid,
  input  logic [31:0]        i_redirect_pc,
  output logic               o_inst_valid,
  output logic [31:0]        o_inst_out,
  output logic [31:0]        o_inst_pc,
  output logic [2:0]         o_immsel
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_flush_addr;
  logic         r_inst_valid;
  logic [31:0]  r_inst_out;
  logic [31:0]  r_inst_pc;
  logic [2:0]   r_immsel;

  logic [31:0]  w_redirect_pc;
  logic [2:0]   w_immsel;
  logic         w_unused_redirect_bits;

  assign w_redirect_pc          = word_align(i_redirect_pc);
  assign w_unused_redirect_bits = &{1'b0, i_redirect_pc[1:0]};

  imm_sel_decode u_imm_sel_decode (
    .i_opcode (imem.imem_rdata[6:0]),
    .o_immsel (w_immsel)
  );

  // FLUSH keeps the abandoned request's address on the bus until it is accepted.
  assign imem.imem_req  = ((r_state == FETCH) || (r_state == FLUSH)) && !rst;
  assign imem.imem_addr = (r_state == FLUSH) ? r_flush_addr : r_pc;

  // Fetch FSM with registered instruction outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_flush_addr <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_inst_out   <= NOP_INST;
      r_inst_pc    <= RESET_PC;
      r_immsel     <= IMM_I;
    end else begin
      case (r_state)
        FETCH: begin
          if (i_redirect_valid) begin
            r_pc <= w_redirect_pc;
            if (imem.imem_ready) begin
              r_state <= FETCH;
            end else begin
              r_flush_addr <= r_pc;
              r_state      <= FLUSH;
            end
          end else if (imem.imem_ready) begin
            r_inst_out   <= imem.imem_rdata;
            r_inst_pc    <= r_pc;
            r_immsel     <= w_immsel;
            r_inst_valid <= 1'b1;
            r_pc         <= r_pc + 32'd4;
            r_state      <= VALID;
          end else begin
            r_state <= FETCH;
          end
        end
        VALID: begin
          // Redirect kills the held instruction even while decode is stalled.
          if (i_redirect_valid) begin
            r_pc         <= w_redirect_pc;
            r_inst_valid <= 1'b0;
            r_state      <= FETCH;
          end else if (i_stall) begin
            r_state <= VALID;
          end else begin
            r_inst_valid <= 1'b0;
            r_state      <= FETCH;
          end
        end
        FLUSH: begin
          if (i_redirect_valid) begin
            r_pc <= w_redirect_pc;
          end else begin
            r_pc <= r_pc;
          end
          if (imem.imem_ready) begin
            r_state <= FETCH;
          end else begin
            r_state <= FLUSH;
          end
        end
        default: begin
          r_inst_valid <= 1'b0;
          r_state      <= FETCH;
        end
      endcase
    end
  end

  assign o_inst_valid = r_inst_valid;
  assign o_inst_out   = r_inst_out;
  assign o_inst_pc    = r_inst_pc;
  assign o_immsel     = r_immsel;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a default-PC instance for handshake, stall and
// redirect behaviour, and a wrap-PC instance for PC wrap and immsel decode.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  sel;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redir;
  logic [31:0] redir_pc;
  logic        valid1, valid2;
  logic [31:0] inst1, inst2, ipc1, ipc2;
  logic [2:0]  sel1, sel2;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  fetch_unit_if bus1 ();
  fetch_unit_if bus2 ();

  fetch_unit dut1 (
    .clk(clk), .rst(rst), .imem(bus1),
    .i_stall(stall), .i_redirect_valid(redir), .i_redirect_pc(redir_pc),
    .o_inst_valid(valid1), .o_inst_out(inst1), .o_inst_pc(ipc1), .o_immsel(sel1)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .imem(bus2),
    .i_stall(1'b0), .i_redirect_valid(1'b0), .i_redirect_pc(32'h0000_0000),
    .o_inst_valid(valid2), .o_inst_out(inst2), .o_inst_pc(ipc2), .o_immsel(sel2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic v, input logic [31:0] inst,
                         input logic [31:0] pc, input logic [2:0] sel);
    exp_t e;
    chk({tag, ".valid"}, {31'd0, v}, 32'd1);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".inst"}, inst, e.inst);
      chk({tag, ".pc"}, pc, e.pc);
      chk({tag, ".sel"}, {29'd0, sel}, {29'd0, e.sel});
    end
  endtask

  logic [31:0] words [6];
  logic [2:0]  sels  [6];
  logic [31:0] pc2;

  initial begin
    words[0] = 32'h0000_00B7; sels[0] = 3'b000;
    words[1] = 32'h0000_006F; sels[1] = 3'b001;
    words[2] = 32'h0000_2083; sels[2] = 3'b010;
    words[3] = 32'h0011_2023; sels[3] = 3'b100;
    words[4] = 32'h0000_0063; sels[4] = 3'b011;
    words[5] = 32'h0020_81B3; sels[5] = 3'b111;

    rst = 1'b1; stall = 1'b0; redir = 1'b0; redir_pc = 32'h0000_0000;
    bus1.imem_ready = 1'b0; bus1.imem_rdata = 32'h0000_0000;
    bus2.imem_ready = 1'b0; bus2.imem_rdata = 32'h0000_0000;
    cyc(); cyc();

    // Reset state
    chk("rst.req", {31'd0, bus1.imem_req}, 32'd0);
    chk("rst.valid", {31'd0, valid1}, 32'd0);
    chk("rst.inst", inst1, 32'h0000_0013);
    chk("rst.pc", ipc1, 32'h0100_0000);
    chk("rst.sel", {29'd0, sel1}, 32'd2);
    chk("rst.pc2", ipc2, 32'hFFFF_FFFC);

    rst = 1'b0;
    #1;
    chk("t1.req", {31'd0, bus1.imem_req}, 32'd1);
    chk("t1.addr", bus1.imem_addr, 32'h0100_0000);

    // Straight-line fetch, always-ready memory
    bus1.imem_ready = 1'b1; bus1.imem_rdata = 32'h0050_0093;
    sb.push_back('{32'h0050_0093, 32'h0100_0000, 3'b010});
    cyc();
    pop_chk("t1", valid1, inst1, ipc1, sel1);
    chk("t1.noreq", {31'd0, bus1.imem_req}, 32'd0);
    cyc();
    chk("t1.next", bus1.imem_addr, 32'h0100_0004);
    chk("t1.v0", {31'd0, valid1}, 32'd0);

    // Wait states
    bus1.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2.addr", bus1.imem_addr, 32'h0100_0004);
      chk("t2.v0", {31'd0, valid1}, 32'd0);
    end
    bus1.imem_ready = 1'b1; bus1.imem_rdata = 32'hFE20_8EE3;
    sb.push_back('{32'hFE20_8EE3, 32'h0100_0004, 3'b011});
    cyc();
    pop_chk("t2", valid1, inst1, ipc1, sel1);

    // Stall holds VALID
    stall = 1'b1; bus1.imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t3.valid", {31'd0, valid1}, 32'd1);
      chk("t3.inst", inst1, 32'hFE20_8EE3);
      chk("t3.sel", {29'd0, sel1}, 32'd3);
      chk("t3.req", {31'd0, bus1.imem_req}, 32'd0);
    end
    stall = 1'b0;
    cyc();
    chk("t3.resume.req", {31'd0, bus1.imem_req}, 32'd1);
    chk("t3.resume.addr", bus1.imem_addr, 32'h0100_0008);

    // Redirect beats stall in VALID
    bus1.imem_ready = 1'b1; bus1.imem_rdata = 32'h00A0_0113;
    sb.push_back('{32'h00A0_0113, 32'h0100_0008, 3'b010});
    cyc();
    pop_chk("t4", valid1, inst1, ipc1, sel1);
    bus1.imem_ready = 1'b0; stall = 1'b1; redir = 1'b1; redir_pc = 32'h0100_0102;
    cyc();
    chk("t4.v0", {31'd0, valid1}, 32'd0);
    chk("t4.addr", bus1.imem_addr, 32'h0100_0100);
    chk("t4.req", {31'd0, bus1.imem_req}, 32'd1);
    stall = 1'b0; redir = 1'b0;

    // Redirect while waiting: old address held, response dropped
    redir = 1'b1; redir_pc = 32'h0100_0040;
    cyc();
    redir = 1'b0;
    chk("t5.hold", bus1.imem_addr, 32'h0100_0100);
    chk("t5.req", {31'd0, bus1.imem_req}, 32'd1);
    cyc();
    chk("t5.hold2", bus1.imem_addr, 32'h0100_0100);
    bus1.imem_ready = 1'b1; bus1.imem_rdata = 32'hDEAD_BEEF;
    cyc();
    chk("t5.drop", {31'd0, valid1}, 32'd0);
    chk("t5.addr", bus1.imem_addr, 32'h0100_0040);
    bus1.imem_rdata = 32'h00C0_00EF;
    sb.push_back('{32'h00C0_00EF, 32'h0100_0040, 3'b001});
    cyc();
    pop_chk("t5", valid1, inst1, ipc1, sel1);
    cyc();
    chk("t5.next", bus1.imem_addr, 32'h0100_0044);

    // Redirect coinciding with ready in FETCH discards the word
    redir = 1'b1; redir_pc = 32'h0100_0203;
    cyc();
    redir = 1'b0; bus1.imem_ready = 1'b0;
    chk("t6.v0", {31'd0, valid1}, 32'd0);
    chk("t6.addr", bus1.imem_addr, 32'h0100_0200);

    // Wrap-around and immsel sweep
    chk("t7.addr0", bus2.imem_addr, 32'hFFFF_FFFC);
    pc2 = 32'hFFFF_FFFC;
    for (int i = 0; i < 6; i++) begin
      bus2.imem_ready = 1'b1; bus2.imem_rdata = words[i];
      sb.push_back('{words[i], pc2, sels[i]});
      cyc();
      pop_chk("t7", valid2, inst2, ipc2, sel2);
      bus2.imem_ready = 1'b0;
      cyc();
      pc2 = pc2 + 32'd4;
      chk("t7.addr", bus2.imem_addr, pc2);
    end

    chk("sb.empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
